// File: rtl/out_port_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : out_port_buffer_if
//  Purpose  : Bundles the control-side write strobe and bus word, the device
//             valid/ready drain handshake and the buffer status flags.
//  Revision : 1.0  initial release
// ============================================================================
interface out_port_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = 2
);
  logic                  OutPortin;
  logic [DATA_WIDTH-1:0] BusMuxOut;
  logic [DATA_WIDTH-1:0] OutPort_out;
  logic [DATA_WIDTH-1:0] dev_data;
  logic                  dev_valid;
  logic                  dev_ready;
  logic                  full;
  logic                  empty;
  logic [PTR_WIDTH:0]    count;
  logic                  out_stall;
  logic                  overflow;

  // Control unit and external device drive the strobe, the bus and ready.
  modport master (
    output OutPortin, BusMuxOut, dev_ready,
    input  OutPort_out, dev_data, dev_valid, full, empty, count, out_stall, overflow
  );

  // The buffer itself.
  modport slave (
    input  OutPortin, BusMuxOut, dev_ready,
    output OutPort_out, dev_data, dev_valid, full, empty, count, out_stall, overflow
  );
endinterface
`default_nettype wire

// File: rtl/out_port_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : out_port_buffer
//  Purpose  : Output-port register plus a small show-ahead FIFO drained by an
//             external device. One word is captured per rising edge of the
//             OutPortin strobe; a stall flag is raised while the queue is full
//             and a sticky overflow flag records dropped writes.
//  Revision : 1.0  initial release
// ============================================================================
module out_port_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  wire                clock,
  input  wire                clear,
  out_port_buffer_if.slave   bus
);

  localparam logic [PTR_WIDTH:0]   c_DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   c_CNT_ONE   = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] c_PTR_ONE   = PTR_WIDTH'(1);

  // Registered state
  logic                  prev_strobe_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr_q;
  logic [PTR_WIDTH-1:0]  rptr_q;
  logic [PTR_WIDTH:0]    count_q;
  logic [PTR_WIDTH:0]    count_d;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] outport_q;

  // Decoded controls
  logic w_full;
  logic w_empty;
  logic w_push_req;
  logic w_pop;
  logic w_accept;
  logic w_drop;

  // Flags come only from registered count, so no path from ready or strobe.
  assign w_full     = (count_q == c_DEPTH_CNT);
  assign w_empty    = (count_q == '0);
  assign w_push_req = bus.OutPortin & ~prev_strobe_q;
  assign w_pop      = ~w_empty & bus.dev_ready;
  // A pop in the same cycle frees a slot, so a push at full still fits.
  assign w_accept   = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  // Occupancy next-state: net change of accepted pushes and pops.
  always_comb begin
    count_d = count_q;
    unique case ({w_accept, w_pop})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointers, count, strobe history, sticky overflow and out-port register.
  always_ff @(posedge clock) begin
    if (clear) begin
      prev_strobe_q <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      outport_q     <= '0;
    end else begin
      prev_strobe_q <= bus.OutPortin;
      count_q       <= count_d;
      if (w_accept) begin
        wptr_q    <= wptr_q + c_PTR_ONE;
        outport_q <= bus.BusMuxOut;
      end
      if (w_pop) begin
        rptr_q <= rptr_q + c_PTR_ONE;
      end
      if (w_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage array; contents are deliberately not reset, dev_valid guards reads.
  always_ff @(posedge clock) begin
    if (w_accept && !clear) begin
      mem_q[wptr_q] <= bus.BusMuxOut;
    end
  end

  assign bus.OutPort_out = outport_q;
  assign bus.dev_data    = mem_q[rptr_q];
  assign bus.dev_valid   = ~w_empty;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.count       = count_q;
  assign bus.out_stall   = w_full;
  assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: doc/out_port_buffer.md
Name: out_port_buffer

Overview:
- Output-port stage directly downstream of the datapath's `out` instruction step (Rout + Gra + OutPortin).
- Captures the word on the datapath bus when OutPortin is asserted and exposes it on OutPort_out.
- Also queues each captured word in a small FIFO, drained by an external device over a valid/ready handshake.
- Raises a stall flag so the control unit can hold its state machine while the queue is full.

Parameters:
- DATA_WIDTH, 32, width of bus and port words.
- DEPTH, 4, FIFO entries (power of two, 2..16).
- PTR_WIDTH, 2, log2(DEPTH).

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- clear  input  1  reset, synchronous, active-high.
- OutPortin  input  1  write strobe from control; may be held high for more than one cycle.
- BusMuxOut  input  DATA_WIDTH  datapath bus value.
- OutPort_out  output  DATA_WIDTH  last accepted word (architectural out-port register).
- dev_data  output  DATA_WIDTH  FIFO head word to the external device.
- dev_valid  output  1  FIFO non-empty.
- dev_ready  input  1  device accepts head this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  PTR_WIDTH+1  occupancy, 0..DEPTH.
- out_stall  output  1  equals full; control holds while high.
- overflow  output  1  sticky dropped-write flag.

Behaviour:
- Reset (clear high at a rising edge):
  - OutPort_out = 0, count = 0, read/write pointers = 0, overflow = 0, strobe history = 0.
  - dev_valid = 0, empty = 1, full = 0, out_stall = 0.
  - Clear wins over any simultaneous push or pop; an in-progress burst is discarded.
- Strobe edge detect:
  - A register holds the previous OutPortin value.
  - push_req = OutPortin & ~prev; one push per strobe assertion regardless of hold length.
  - prev is cleared by clear.
- Pop: pop = dev_valid & dev_ready.
- Push acceptance: accepted if push_req & (~full | pop).
- On accept, at the same edge:
  - mem[wptr] <= BusMuxOut; wptr increments mod DEPTH.
  - OutPort_out <= BusMuxOut, so it is visible one cycle after the strobe edge.
- On pop: rptr increments mod DEPTH.
- count update:
  - +1 on accept without pop.
  - -1 on pop without accept.
  - unchanged on both or neither.
- Show-ahead output: dev_data = mem[rptr] combinationally from registered state. Its value while empty is don't-care but stable (last slot content).
- Latency: strobe edge at cycle N gives dev_valid = 1 and dev_data = word at cycle N+1 when the FIFO was empty.
- Simultaneous push and pop when full:
  - Both occur; count stays DEPTH; the new word goes into the freed slot order-correctly.
- Push while full without pop:
  - Word dropped; FIFO and OutPort_out unchanged; overflow <= 1, held until clear.
- Pop while empty: impossible by construction (dev_valid = 0); dev_ready is ignored.
- Pointer wrap: DEPTH is a power of two, so pointers wrap naturally; full/empty are derived from count, not pointer compare.
- Flag timing: full, empty, out_stall and dev_valid are decoded from registered count with no combinational path from dev_ready or OutPortin.
- FIFO contents are not reset (only pointers and count); reading before any write is prevented by dev_valid.

Test Plan:
- Single out: reset, BusMuxOut = 53, OutPortin high 2 cycles, dev_ready = 0 -> after first edge OutPort_out = 53, dev_data = 53, dev_valid = 1, count = 1 (not 2).
- Fill and stall: DEPTH = 4, four strobes with 1, 2, 3, 4, dev_ready = 0 -> full = out_stall = 1, count = 4; fifth strobe with 5 -> overflow = 1, OutPort_out stays 4, count stays 4.
- Drain order: from the full state, hold dev_ready = 1 -> dev_data sequence 1, 2, 3, 4 on consecutive cycles, then empty = 1, dev_valid = 0.
- Push+pop at full: full with 10, 11, 12, 13, strobe with 14 and dev_ready = 1 in the same cycle -> count = 4, no overflow, drain yields 11, 12, 13, 14.
- Wrap: repeat push/pop pairs 9 times with values 100..108 -> each returned in order, count returns to 0, pointers wrap cleanly.
- Reset mid-operation: 3 words queued, overflow set, assert clear for one cycle with OutPortin rising -> count = 0, overflow = 0, OutPort_out = 0, no push recorded.
